// File: rtl/sm83_irq_ctrl_if.sv
// rtl/sm83_irq_ctrl_if.sv - CPU-side bus between the SM83 core and its interrupt controller
interface sm83_irq_ctrl_if #(
  parameter int NUM_SRC = 5
);
  logic [NUM_SRC-1:0] irq_req;
  logic               if_wr_en;
  logic [7:0]         if_wr_data;
  logic               ie_wr_en;
  logic [7:0]         ie_wr_data;
  logic [7:0]         if_rd_data;
  logic [7:0]         ie_rd_data;
  logic               ctl_di;
  logic               ctl_ei;
  logic               ctl_reti;
  logic               instr_boundary;
  logic               dispatch_req;
  logic [15:0]        dispatch_vec;
  logic               dispatch_ack;
  logic               ime;
  logic               wake;

  modport slave (
    input  irq_req, if_wr_en, if_wr_data, ie_wr_en, ie_wr_data,
    input  ctl_di, ctl_ei, ctl_reti, instr_boundary, dispatch_ack,
    output if_rd_data, ie_rd_data, dispatch_req, dispatch_vec, ime, wake
  );

  modport master (
    output irq_req, if_wr_en, if_wr_data, ie_wr_en, ie_wr_data,
    output ctl_di, ctl_ei, ctl_reti, instr_boundary, dispatch_ack,
    input  if_rd_data, ie_rd_data, dispatch_req, dispatch_vec, ime, wake
  );
endinterface

// File: rtl/sm83_irq_ctrl.sv
// rtl/sm83_irq_ctrl.sv - SM83 interrupt controller: IF/IE registers, IME with delayed EI, vectored dispatch
module sm83_irq_ctrl #(
  parameter int          NUM_SRC    = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
  input logic           clk,
  input logic           rst,
  sm83_irq_ctrl_if.slave bus
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] if_q, if_n;
  logic [7:0]         ie_q, ie_n;
  logic               ime_q, ime_n;
  logic               ei_pend, ei_pend_n;
  logic [2:0]         src_q, src_n;
  logic [NUM_SRC-1:0] pending;
  logic [2:0]         first_src;
  logic               start;

  assign pending = ie_q[NUM_SRC-1:0] & if_q;

  // Fixed priority: scan from the top so the lowest set index is left last.
  always_comb begin
    first_src = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) first_src = 3'(i);
    end
  end

  assign start = (state == IDLE) && ime_q && (|pending) && bus.instr_boundary;

  always_comb begin
    state_n   = state;
    if_n      = if_q;
    ie_n      = ie_q;
    ime_n     = ime_q;
    ei_pend_n = ei_pend;
    src_n     = src_q;

    if (bus.ie_wr_en) ie_n = bus.ie_wr_data;

    // Write, then ack clear, then hardware set: a new request is never lost.
    if (bus.if_wr_en) if_n = bus.if_wr_data[NUM_SRC-1:0];
    if (state == REQ && bus.dispatch_ack) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (3'(i) == src_q) if_n[i] = 1'b0;
      end
    end
    if_n = if_n | bus.irq_req;

    if (ei_pend && bus.instr_boundary) begin
      ime_n     = 1'b1;
      ei_pend_n = 1'b0;
    end
    if (bus.ctl_ei) ei_pend_n = 1'b1;
    if (bus.ctl_reti) begin
      ime_n     = 1'b1;
      ei_pend_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = REQ;
          src_n     = first_src;
          ime_n     = 1'b0;
          ei_pend_n = 1'b0;
        end
      end
      REQ: begin
        if (bus.dispatch_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // DI is applied last so it overrides EI and RETI in the same cycle.
    if (bus.ctl_di) begin
      ime_n     = 1'b0;
      ei_pend_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      if_q    <= '0;
      ie_q    <= 8'h00;
      ime_q   <= 1'b0;
      ei_pend <= 1'b0;
      src_q   <= 3'd0;
    end else begin
      state   <= state_n;
      if_q    <= if_n;
      ie_q    <= ie_n;
      ime_q   <= ime_n;
      ei_pend <= ei_pend_n;
      src_q   <= src_n;
    end
  end

  always_comb begin
    bus.if_rd_data = 8'hFF;
    bus.if_rd_data[NUM_SRC-1:0] = if_q;
  end

  assign bus.ie_rd_data   = ie_q;
  assign bus.ime          = ime_q;
  assign bus.wake         = |pending;
  assign bus.dispatch_req = (state == REQ);
  assign bus.dispatch_vec = (state == REQ) ? 16'(VEC_BASE + {13'd0, src_q} * VEC_STRIDE)
                                           : VEC_BASE;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// tb/tb_sm83_irq_ctrl.sv - scoreboard bench for sm83_irq_ctrl (NUM_SRC=5 and NUM_SRC=8 instances)
module tb_sm83_irq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm83_irq_ctrl_if #(.NUM_SRC(5)) b0 ();
  sm83_irq_ctrl_if #(.NUM_SRC(8)) b1 ();

  sm83_irq_ctrl #(.NUM_SRC(5), .VEC_BASE(16'h0040), .VEC_STRIDE(16'h0008)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  sm83_irq_ctrl #(.NUM_SRC(8), .VEC_BASE(16'h0040), .VEC_STRIDE(16'h0010)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  typedef struct {
    string       name;
    int          inst;
    logic [7:0]  ifv;
    logic [7:0]  iev;
    logic        ime;
    logic        wake;
    logic        req;
    logic [15:0] vec;
  } snap_t;

  typedef struct {
    int          inst;
    logic [15:0] vec;
  } disp_t;

  snap_t snap_q[$];
  disp_t disp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  prev_req0 = 1'b0;
  logic  prev_req1 = 1'b0;

  task automatic clear_inputs();
    b0.irq_req = '0; b0.if_wr_en = 0; b0.ie_wr_en = 0; b0.ctl_di = 0; b0.ctl_ei = 0;
    b0.ctl_reti = 0; b0.instr_boundary = 0; b0.dispatch_ack = 0;
    b1.irq_req = '0; b1.if_wr_en = 0; b1.ie_wr_en = 0; b1.ctl_di = 0; b1.ctl_ei = 0;
    b1.ctl_reti = 0; b1.instr_boundary = 0; b1.dispatch_ack = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_state(input string name, input int inst, input logic [7:0] ifv,
                              input logic [7:0] iev, input logic ime, input logic wake,
                              input logic req, input logic [15:0] vec);
    snap_t s;
    s.name = name; s.inst = inst; s.ifv = ifv; s.iev = iev;
    s.ime = ime; s.wake = wake; s.req = req; s.vec = vec;
    snap_q.push_back(s);
  endtask

  task automatic expect_dispatch(input int inst, input logic [15:0] vec);
    disp_t d;
    d.inst = inst; d.vec = vec;
    disp_q.push_back(d);
  endtask

  // Monitor: drains state snapshots and checks every rising dispatch_req against the queue.
  always @(negedge clk) begin
    while (snap_q.size() > 0) begin
      snap_t s;
      logic [7:0] a_if, a_ie;
      logic a_ime, a_wake, a_req;
      logic [15:0] a_vec;
      s = snap_q.pop_front();
      if (s.inst == 0) begin
        a_if = b0.if_rd_data; a_ie = b0.ie_rd_data; a_ime = b0.ime;
        a_wake = b0.wake; a_req = b0.dispatch_req; a_vec = b0.dispatch_vec;
      end else begin
        a_if = b1.if_rd_data; a_ie = b1.ie_rd_data; a_ime = b1.ime;
        a_wake = b1.wake; a_req = b1.dispatch_req; a_vec = b1.dispatch_vec;
      end
      n_tests++;
      if (a_if !== s.ifv || a_ie !== s.iev || a_ime !== s.ime || a_wake !== s.wake ||
          a_req !== s.req || a_vec !== s.vec) begin
        n_fail++;
        $display("FAIL %s: got if=%h ie=%h ime=%b wake=%b req=%b vec=%h, expected if=%h ie=%h ime=%b wake=%b req=%b vec=%h",
                 s.name, a_if, a_ie, a_ime, a_wake, a_req, a_vec,
                 s.ifv, s.iev, s.ime, s.wake, s.req, s.vec);
      end
    end
    for (int k = 0; k < 2; k++) begin
      logic cur, prv;
      logic [15:0] v;
      cur = (k == 0) ? b0.dispatch_req : b1.dispatch_req;
      prv = (k == 0) ? prev_req0 : prev_req1;
      v   = (k == 0) ? b0.dispatch_vec : b1.dispatch_vec;
      if (cur === 1'b1 && prv !== 1'b1) begin
        n_tests++;
        if (disp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_dispatch: inst %0d vec=%h, expected no dispatch", k, v);
        end else begin
          disp_t d;
          d = disp_q.pop_front();
          if (d.inst != k || v !== d.vec) begin
            n_fail++;
            $display("FAIL dispatch_vec: got inst %0d vec=%h, expected inst %0d vec=%h",
                     k, v, d.inst, d.vec);
          end
        end
      end
    end
    prev_req0 <= b0.dispatch_req;
    prev_req1 <= b1.dispatch_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.if_wr_data = 8'h00; b0.ie_wr_data = 8'h00;
    b1.if_wr_data = 8'h00; b1.ie_wr_data = 8'h00;
    clear_inputs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    expect_state("reset0", 0, 8'hE0, 8'h00, 0, 0, 0, 16'h0040);
    expect_state("reset1", 1, 8'h00, 8'h00, 0, 0, 0, 16'h0040);

    // Priority: sources 2 and 4 pending, source 2 wins
    b0.ie_wr_en = 1; b0.ie_wr_data = 8'h1F; b0.ctl_reti = 1; cyc();
    expect_state("reti_ime", 0, 8'hE0, 8'h1F, 1, 0, 0, 16'h0040);
    b0.irq_req = 5'b10100; cyc();
    expect_state("irq_set", 0, 8'hF4, 8'h1F, 1, 1, 0, 16'h0040);
    expect_dispatch(0, 16'h0050);
    b0.instr_boundary = 1; cyc();
    expect_state("prio_req", 0, 8'hF4, 8'h1F, 0, 1, 1, 16'h0050);
    cyc();
    expect_state("prio_hold", 0, 8'hF4, 8'h1F, 0, 1, 1, 16'h0050);
    b0.dispatch_ack = 1; cyc();
    expect_state("prio_ack", 0, 8'hF0, 8'h1F, 0, 1, 0, 16'h0040);

    // Ack while idle is ignored
    b0.dispatch_ack = 1; cyc();
    expect_state("ack_idle", 0, 8'hF0, 8'h1F, 0, 1, 0, 16'h0040);

    // EI delay: first boundary only enables IME, second one dispatches source 4
    b0.ctl_ei = 1; cyc();
    expect_state("ei_armed", 0, 8'hF0, 8'h1F, 0, 1, 0, 16'h0040);
    expect_dispatch(0, 16'h0060);
    b0.instr_boundary = 1; cyc();
    expect_state("ei_bound1", 0, 8'hF0, 8'h1F, 1, 1, 0, 16'h0040);
    b0.instr_boundary = 1; cyc();
    expect_state("ei_bound2", 0, 8'hF0, 8'h1F, 0, 1, 1, 16'h0060);
    b0.dispatch_ack = 1; cyc();
    expect_state("ei_ack", 0, 8'hE0, 8'h1F, 0, 0, 0, 16'h0040);

    // Collision: irq_req[0] in the same cycle as the ack of source 0
    b0.ctl_reti = 1; b0.irq_req = 5'b00001; cyc();
    expect_state("col_setup", 0, 8'hE1, 8'h1F, 1, 1, 0, 16'h0040);
    expect_dispatch(0, 16'h0040);
    b0.instr_boundary = 1; cyc();
    expect_state("col_req", 0, 8'hE1, 8'h1F, 0, 1, 1, 16'h0040);
    b0.dispatch_ack = 1; b0.irq_req = 5'b00001; cyc();
    expect_state("col_ack", 0, 8'hE1, 8'h1F, 0, 1, 0, 16'h0040);
    b0.instr_boundary = 1; cyc();
    expect_state("col_noredisp", 0, 8'hE1, 8'h1F, 0, 1, 0, 16'h0040);

    // DI with EI: DI wins, no later enable
    b0.ctl_di = 1; b0.ctl_ei = 1; cyc();
    expect_state("di_ei", 0, 8'hE1, 8'h1F, 0, 1, 0, 16'h0040);
    b0.instr_boundary = 1; cyc();
    b0.instr_boundary = 1; cyc();
    expect_state("di_ei_bound", 0, 8'hE1, 8'h1F, 0, 1, 0, 16'h0040);
    // DI after EI cancels the pending enable
    b0.ctl_ei = 1; cyc();
    b0.ctl_di = 1; cyc();
    b0.instr_boundary = 1; cyc();
    expect_state("di_cancel_ei", 0, 8'hE1, 8'h1F, 0, 1, 0, 16'h0040);
    b0.ctl_reti = 1; cyc();
    expect_state("reti", 0, 8'hE1, 8'h1F, 1, 1, 0, 16'h0040);
    b0.ctl_di = 1; cyc();
    expect_state("di", 0, 8'hE1, 8'h1F, 0, 1, 0, 16'h0040);

    // Wake with IME off
    b0.ie_wr_en = 1; b0.ie_wr_data = 8'h04; b0.if_wr_en = 1; b0.if_wr_data = 8'h04; cyc();
    expect_state("wake", 0, 8'hE4, 8'h04, 0, 1, 0, 16'h0040);

    // Reset during REQ abandons the dispatch
    b0.ctl_reti = 1; cyc();
    expect_dispatch(0, 16'h0050);
    b0.instr_boundary = 1; cyc();
    expect_state("rst_req", 0, 8'hE4, 8'h04, 0, 1, 1, 16'h0050);
    rst = 1'b1; b0.dispatch_ack = 1; cyc();
    rst = 1'b0;
    expect_state("rst_in_req", 0, 8'hE0, 8'h00, 0, 0, 0, 16'h0040);

    // Hardware set beats a software write of 0
    b0.if_wr_en = 1; b0.if_wr_data = 8'h03; cyc();
    expect_state("if_write", 0, 8'hE3, 8'h00, 0, 0, 0, 16'h0040);
    b0.if_wr_en = 1; b0.if_wr_data = 8'h00; b0.irq_req = 5'b00010; cyc();
    expect_state("set_beats_write", 0, 8'hE2, 8'h00, 0, 0, 0, 16'h0040);

    // Eight sources, stride 16: source 7 vectors to 0x00B0
    b1.ie_wr_en = 1; b1.ie_wr_data = 8'h80; b1.ctl_reti = 1; b1.irq_req = 8'h80; cyc();
    expect_state("n8_setup", 1, 8'h80, 8'h80, 1, 1, 0, 16'h0040);
    expect_dispatch(1, 16'h00B0);
    b1.instr_boundary = 1; cyc();
    expect_state("n8_req", 1, 8'h80, 8'h80, 0, 1, 1, 16'h00B0);
    b1.dispatch_ack = 1; cyc();
    expect_state("n8_ack", 1, 8'h00, 8'h80, 0, 0, 0, 16'h0040);

    cyc(); cyc();
    n_tests++;
    if (disp_q.size() != 0) begin
      n_fail++;
      $display("FAIL dispatch_drain: %0d expected dispatches never seen, expected 0", disp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
